// File: rtl/mux3_arbiter_pkg.sv
// Shared constants and helpers for the three-way round-robin datapath arbiter.
package mux3_arbiter_pkg;

  localparam int unsigned NUM_REQ = 3;
  localparam int unsigned IDX_W   = 2;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam logic [IDX_W-1:0] REQ0 = 2'd0;
  localparam logic [IDX_W-1:0] REQ1 = 2'd1;
  localparam logic [IDX_W-1:0] REQ2 = 2'd2;

  // Successor of a requester index, wrapping 2 -> 0.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i >= REQ2) ? REQ0 : IDX_W'(i + IDX_W'(1));
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot3(input logic [IDX_W-1:0] i);
    logic [NUM_REQ-1:0] oh;
    case (i)
      REQ0:    oh = 3'b001;
      REQ1:    oh = 3'b010;
      REQ2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/mux3_arbiter_rr_pick3.sv
// Combinational round-robin pick: first asserted request scanning ptr, ptr+1, ptr+2.
module rr_pick3
  import mux3_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   winner_c,
  output logic               any_c
);

  logic [IDX_W-1:0] i0, i1, i2;

  assign i0 = ptr;
  assign i1 = next_idx(i0);
  assign i2 = next_idx(i1);

  // Lowest-priority candidate assigned first so the highest-priority one wins.
  always_comb begin
    winner_c = REQ0;
    any_c    = |req;
    if (req[i2]) winner_c = i2;
    if (req[i1]) winner_c = i1;
    if (req[i0]) winner_c = i0;
  end

endmodule

// File: rtl/mux3_arbiter.sv
// Round-robin burst arbiter driving the select of a 3-to-1 datapath mux.
module mux3_arbiter
  import mux3_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BEATS = 16,
  parameter int unsigned CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] last,
  input  logic               bus_ready,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   sel,
  output logic               bus_valid,
  output logic               busy,
  output logic [CNT_W-1:0]   beat_cnt
);

  logic [0:0]         state, state_nxt;
  logic [IDX_W-1:0]   ptr, ptr_nxt, sel_nxt;
  logic [NUM_REQ-1:0] gnt_nxt;
  logic [CNT_W-1:0]   cnt_nxt, cnt_inc;
  logic [IDX_W-1:0]   winner_c;
  logic               any_c;
  logic               g_req, g_last, xfer;

  rr_pick3 u_pick (
    .req      (req),
    .ptr      (ptr),
    .winner_c (winner_c),
    .any_c    (any_c)
  );

  // gnt is one-hot while granted, so masking selects the granted requester's flags.
  assign g_req     = |(req & gnt);
  assign g_last    = |(last & gnt);
  assign bus_valid = (state == ST_GRANT) && g_req;
  assign xfer      = bus_valid && bus_ready;
  assign cnt_inc   = beat_cnt + CNT_W'(1);

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    sel_nxt   = sel;
    cnt_nxt   = beat_cnt;
    ptr_nxt   = ptr;
    case (state)
      ST_IDLE: begin
        if (any_c) begin
          state_nxt = ST_GRANT;
          gnt_nxt   = onehot3(winner_c);
          sel_nxt   = winner_c;
          cnt_nxt   = '0;
        end
      end
      default: begin
        if (xfer) cnt_nxt = cnt_inc;
        // sel and beat_cnt deliberately hold their final values after release.
        if (!g_req || (xfer && (g_last || cnt_inc == CNT_W'(MAX_BEATS)))) begin
          state_nxt = ST_IDLE;
          gnt_nxt   = '0;
          ptr_nxt   = next_idx(sel);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      gnt      <= '0;
      sel      <= REQ0;
      beat_cnt <= '0;
      ptr      <= REQ0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      sel      <= sel_nxt;
      beat_cnt <= cnt_nxt;
      ptr      <= ptr_nxt;
      busy     <= (state_nxt == ST_GRANT);
    end
  end

endmodule

// File: tb/tb_mux3_arbiter.sv
// Directed self-checking bench for mux3_arbiter with hand-computed expectations.
module tb_mux3_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] req, last;
  logic       bus_ready;
  logic [2:0] gnt;
  logic [1:0] sel;
  logic       bus_valid, busy;
  logic [7:0] beat_cnt;

  int n_checks = 0;
  int n_errors = 0;

  mux3_arbiter #(.MAX_BEATS(16), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .last      (last),
    .bus_ready (bus_ready),
    .gnt       (gnt),
    .sel       (sel),
    .bus_valid (bus_valid),
    .busy      (busy),
    .beat_cnt  (beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic [2:0] gnt_e, input logic [1:0] sel_e,
                         input logic valid_e, input logic [7:0] cnt_e);
    check({tag, ".gnt"}, 32'(gnt), 32'(gnt_e));
    check({tag, ".sel"}, 32'(sel), 32'(sel_e));
    check({tag, ".valid"}, 32'(bus_valid), 32'(valid_e));
    check({tag, ".busy"}, 32'(busy), 32'(|gnt_e));
    check({tag, ".cnt"}, 32'(beat_cnt), 32'(cnt_e));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int order[4] = '{0, 1, 2, 0};
    logic [2:0] oh;

    rst_n = 1'b0; req = '0; last = '0; bus_ready = 1'b0;
    #2;
    chk_bus("reset", 3'b000, 2'd0, 1'b0, 8'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk_bus("idle", 3'b000, 2'd0, 1'b0, 8'd0);

    // Round robin over all three, last on the 2nd beat, one idle cycle between grants.
    req = 3'b111; bus_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      oh = 3'(1 << order[i]);
      tick();
      chk_bus("rr.grant", oh, 2'(order[i]), 1'b1, 8'd0);
      tick();
      chk_bus("rr.beat1", oh, 2'(order[i]), 1'b1, 8'd1);
      last = 3'b111;
      tick();
      chk_bus("rr.release", 3'b000, 2'(order[i]), 1'b0, 8'd2);
      last = 3'b000;
    end

    // Beat-limit timeout with ptr=1.
    req = 3'b010;
    tick();
    chk_bus("to.grant", 3'b010, 2'd1, 1'b1, 8'd0);
    for (int k = 1; k < 16; k++) begin
      tick();
      chk_bus("to.beat", 3'b010, 2'd1, 1'b1, 8'(k));
    end
    tick();
    chk_bus("to.release", 3'b000, 2'd1, 1'b0, 8'd16);
    tick();
    chk_bus("to.regrant", 3'b010, 2'd1, 1'b1, 8'd0);
    req = 3'b000;
    tick();
    chk_bus("to.withdraw", 3'b000, 2'd1, 1'b0, 8'd0);

    // Stall mid-burst on requester 0; last during stall must be ignored.
    req = 3'b001;
    tick();
    chk_bus("st.grant", 3'b001, 2'd0, 1'b1, 8'd0);
    tick();
    tick();
    chk_bus("st.beat2", 3'b001, 2'd0, 1'b1, 8'd2);
    bus_ready = 1'b0; last = 3'b001;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_bus("st.stall", 3'b001, 2'd0, 1'b1, 8'd2);
    end
    bus_ready = 1'b1; last = 3'b000;
    tick();
    chk_bus("st.resume", 3'b001, 2'd0, 1'b1, 8'd3);
    last = 3'b010;
    tick();
    chk_bus("st.foreign_last", 3'b001, 2'd0, 1'b1, 8'd4);
    last = 3'b001;
    tick();
    chk_bus("st.release", 3'b000, 2'd0, 1'b0, 8'd5);
    last = 3'b000;

    // Grant to 2 (ptr=1), withdraw after 3 beats, pending 0 and 1 -> ptr=0 picks 0.
    req = 3'b100;
    tick();
    chk_bus("wd.grant", 3'b100, 2'd2, 1'b1, 8'd0);
    tick(); tick(); tick();
    chk_bus("wd.beat3", 3'b100, 2'd2, 1'b1, 8'd3);
    req = 3'b011;
    tick();
    chk_bus("wd.release", 3'b000, 2'd2, 1'b0, 8'd3);
    tick();
    chk_bus("wd.next", 3'b001, 2'd0, 1'b1, 8'd0);
    tick();
    chk_bus("wd.beat1", 3'b001, 2'd0, 1'b1, 8'd1);

    // Asynchronous reset pulse mid-burst.
    #1;
    rst_n = 1'b0;
    #1;
    chk_bus("arst", 3'b000, 2'd0, 1'b0, 8'd0);
    #4;
    rst_n = 1'b1;
    req = 3'b100;
    tick();
    chk_bus("arst.regrant", 3'b100, 2'd2, 1'b1, 8'd0);
    req = 3'b000;
    tick();
    chk_bus("arst.withdraw", 3'b000, 2'd2, 1'b0, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
